// File: rtl/orion_video_pkg.sv
// Shared constants and types for the Orion-Pro raster video engine.
//   - Default raster timing (pixels / lines) and interrupt width.
//   - Bitplane RAM segments, cell width, counter widths.
//   - Display mode and fetch FSM state enums.
package orion_video_pkg;

  localparam int DEF_H_ACTIVE     = 384;
  localparam int DEF_H_TOTAL      = 640;
  localparam int DEF_H_SYNC_START = 416;
  localparam int DEF_H_SYNC_LEN   = 64;
  localparam int DEF_V_ACTIVE     = 256;
  localparam int DEF_V_TOTAL      = 312;
  localparam int DEF_V_SYNC_START = 272;
  localparam int DEF_V_SYNC_LEN   = 4;
  localparam int DEF_INT_LEN      = 128;

  localparam logic [4:0] DEF_P0_SEG = 5'h00;
  localparam logic [4:0] DEF_P1_SEG = 5'h01;

  localparam int CELL_W = 8;
  localparam int HCNT_W = 10;
  localparam int VCNT_W = 9;
  localparam int INT_W  = 16;

  typedef enum logic [2:0] {
    MODE_MONO  = 3'd0,
    MODE_BLANK = 3'd1,
    MODE_C4    = 3'd2,
    MODE_C16   = 3'd3
  } mode_e;

  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_REQ_P0 = 2'd1,
    FS_REQ_P1 = 2'd2,
    FS_DONE   = 2'd3
  } fetch_e;

endpackage

// File: rtl/orion_video_timing.sv
// Raster timing for the Orion-Pro video engine.
//   i_clk, i_reset_n (sync, active low), i_pix_ce (pixel tick), i_int_en
//   o_hcnt/o_vcnt : raster position of the pixel processed on the next tick
//   o_vis         : that position is inside the visible area (combinational)
//   o_hsync_n, o_vsync_n, o_de : registered, describe the pixel just ticked
//   o_frame_end   : one-clock pulse on the tick entering the vsync line
//   o_int_n       : frame interrupt, low for INT_LEN ticks when enabled
module orion_video_timing
  import orion_video_pkg::*;
#(
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_TOTAL      = DEF_H_TOTAL,
  parameter int H_SYNC_START = DEF_H_SYNC_START,
  parameter int H_SYNC_LEN   = DEF_H_SYNC_LEN,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_TOTAL      = DEF_V_TOTAL,
  parameter int V_SYNC_START = DEF_V_SYNC_START,
  parameter int V_SYNC_LEN   = DEF_V_SYNC_LEN,
  parameter int INT_LEN      = DEF_INT_LEN
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_pix_ce,
  input  logic              i_int_en,
  output logic [HCNT_W-1:0] o_hcnt,
  output logic [VCNT_W-1:0] o_vcnt,
  output logic              o_vis,
  output logic              o_hsync_n,
  output logic              o_vsync_n,
  output logic              o_de,
  output logic              o_frame_end,
  output logic              o_int_n
);

  localparam logic [HCNT_W-1:0] H_ACT  = HCNT_W'(H_ACTIVE);
  localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(H_TOTAL - 1);
  localparam logic [HCNT_W-1:0] H_SS   = HCNT_W'(H_SYNC_START);
  localparam logic [HCNT_W-1:0] H_SE   = HCNT_W'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [VCNT_W-1:0] V_ACT  = VCNT_W'(V_ACTIVE);
  localparam logic [VCNT_W-1:0] V_LAST = VCNT_W'(V_TOTAL - 1);
  localparam logic [VCNT_W-1:0] V_SS   = VCNT_W'(V_SYNC_START);
  localparam logic [VCNT_W-1:0] V_SE   = VCNT_W'(V_SYNC_START + V_SYNC_LEN);
  localparam logic [INT_W-1:0]  I_LEN  = INT_W'(INT_LEN);

  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d;
  logic [INT_W-1:0]  int_cnt_q, int_cnt_d;
  logic hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d, de_q, de_d;
  logic frame_end_q, frame_end_d, int_n_q, int_n_d;

  always_comb begin
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    hsync_n_d   = hsync_n_q;
    vsync_n_d   = vsync_n_q;
    de_d        = de_q;
    frame_end_d = 1'b0;
    int_cnt_d   = int_cnt_q;
    if (i_pix_ce) begin
      hsync_n_d = !(hcnt_q >= H_SS && hcnt_q < H_SE);
      vsync_n_d = !(vcnt_q >= V_SS && vcnt_q < V_SE);
      de_d      = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
      if (int_cnt_q != '0) int_cnt_d = int_cnt_q - 1'b1;
      if (hcnt_q == H_LAST) begin
        hcnt_d      = '0;
        vcnt_d      = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        frame_end_d = (vcnt_d == V_SS);
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
      if (frame_end_d) int_cnt_d = I_LEN;
    end
    // Dropping the enable kills any interrupt still in progress.
    if (!i_int_en) int_cnt_d = '0;
    int_n_d = (int_cnt_d == '0);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      int_cnt_q   <= '0;
      hsync_n_q   <= 1'b1;
      vsync_n_q   <= 1'b1;
      de_q        <= 1'b0;
      frame_end_q <= 1'b0;
      int_n_q     <= 1'b1;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      int_cnt_q   <= int_cnt_d;
      hsync_n_q   <= hsync_n_d;
      vsync_n_q   <= vsync_n_d;
      de_q        <= de_d;
      frame_end_q <= frame_end_d;
      int_n_q     <= int_n_d;
    end
  end

  assign o_hcnt      = hcnt_q;
  assign o_vcnt      = vcnt_q;
  assign o_vis       = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign o_hsync_n   = hsync_n_q;
  assign o_vsync_n   = vsync_n_q;
  assign o_de        = de_q;
  assign o_frame_end = frame_end_q;
  assign o_int_n     = int_n_q;

endmodule

// File: rtl/orion_pro_video.sv
// Orion-Pro raster video engine.
//   Fetches two bitplane bytes per 8-pixel cell over a req/ack RAM port,
//   one cell ahead of display, and serialises them into 4-bit RGBI.
//   i_clk, i_reset_n (sync, active low), i_pix_ce (pixel tick)
//   i_video_mode, i_screen_mode, i_colors_pseudo, i_int_en : CPU registers
//   o_vram_req/o_vram_addr, i_vram_ack/i_vram_data          : fetch port
//   o_rgbi, o_hsync_n, o_vsync_n, o_de                     : display path
//   o_int_n, o_frame_end                                    : frame interrupt
//   o_underrun : sticky, a cell's fetch had not finished at its load
module orion_pro_video
  import orion_video_pkg::*;
#(
  parameter int         H_ACTIVE     = DEF_H_ACTIVE,
  parameter int         H_TOTAL      = DEF_H_TOTAL,
  parameter int         H_SYNC_START = DEF_H_SYNC_START,
  parameter int         H_SYNC_LEN   = DEF_H_SYNC_LEN,
  parameter int         V_ACTIVE     = DEF_V_ACTIVE,
  parameter int         V_TOTAL      = DEF_V_TOTAL,
  parameter int         V_SYNC_START = DEF_V_SYNC_START,
  parameter int         V_SYNC_LEN   = DEF_V_SYNC_LEN,
  parameter int         INT_LEN      = DEF_INT_LEN,
  parameter logic [4:0] P0_SEG       = DEF_P0_SEG,
  parameter logic [4:0] P1_SEG       = DEF_P1_SEG
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_pix_ce,
  input  logic [4:0]  i_video_mode,
  input  logic [7:0]  i_screen_mode,
  input  logic [7:0]  i_colors_pseudo,
  input  logic        i_int_en,
  output logic        o_vram_req,
  output logic [20:0] o_vram_addr,
  input  logic        i_vram_ack,
  input  logic [7:0]  i_vram_data,
  output logic [3:0]  o_rgbi,
  output logic        o_hsync_n,
  output logic        o_vsync_n,
  output logic        o_de,
  output logic        o_int_n,
  output logic        o_frame_end,
  output logic        o_underrun
);

  // Last fetch start inside a line is for cell 47 (during cell 46); cell 0
  // of the next line is fetched during the last cell slot of this line.
  localparam logic [HCNT_W-1:0] H_LAST_START = HCNT_W'(H_ACTIVE - 2 * CELL_W);
  localparam logic [HCNT_W-1:0] H_PRE        = HCNT_W'(H_TOTAL - CELL_W);
  localparam logic [VCNT_W-1:0] V_LAST       = VCNT_W'(V_TOTAL - 1);
  localparam logic [VCNT_W-1:0] V_ACT        = VCNT_W'(V_ACTIVE);

  logic [HCNT_W-1:0] hcnt;
  logic [VCNT_W-1:0] vcnt;
  logic              vis;

  orion_video_timing #(
    .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL),
    .H_SYNC_START(H_SYNC_START), .H_SYNC_LEN(H_SYNC_LEN),
    .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL),
    .V_SYNC_START(V_SYNC_START), .V_SYNC_LEN(V_SYNC_LEN),
    .INT_LEN(INT_LEN)
  ) u_timing (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_pix_ce   (i_pix_ce),
    .i_int_en   (i_int_en),
    .o_hcnt     (hcnt),
    .o_vcnt     (vcnt),
    .o_vis      (vis),
    .o_hsync_n  (o_hsync_n),
    .o_vsync_n  (o_vsync_n),
    .o_de       (o_de),
    .o_frame_end(o_frame_end),
    .o_int_n    (o_int_n)
  );

  logic unused_regs;
  assign unused_regs = ^{i_video_mode[4:3], i_screen_mode[7:2]};

  // ---------------------------------------------------------------- state
  fetch_e      state_q, state_d;
  logic [1:0]  page_q, page_d;
  logic [15:0] base_q, base_d;       // {~page, cell, row}
  logic [7:0]  hold_p0_q, hold_p0_d, hold_p1_q, hold_p1_d;
  logic        valid_q, valid_d;
  logic        underrun_q, underrun_d;
  logic        req_q, req_d;
  logic [20:0] addr_q, addr_d;
  logic [7:0]  sh_p0_q, sh_p0_d, sh_p1_q, sh_p1_d;
  mode_e       mode_q, mode_d;
  logic        blank_q, blank_d;
  logic [3:0]  rgbi_q, rgbi_d;

  // ------------------------------------------------------------ scheduling
  logic [VCNT_W-1:0] vnext;
  logic              boundary, fetch_start;
  logic [5:0]        start_cell;
  logic [7:0]        start_row;

  always_comb begin
    vnext       = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    boundary    = i_pix_ce && vis && (hcnt[2:0] == 3'd0);
    fetch_start = i_pix_ce &&
                  ((vis && hcnt[2:0] == 3'd0 && hcnt <= H_LAST_START) ||
                   (hcnt == H_PRE && vnext < V_ACT));
    start_cell  = (hcnt == H_PRE) ? 6'd0 : hcnt[8:3] + 6'd1;
    start_row   = (hcnt == H_PRE) ? vnext[7:0] : vcnt[7:0];
    page_d      = (i_pix_ce && hcnt == '0 && vcnt == '0) ? i_screen_mode[1:0] : page_q;
  end

  // ------------------------------------------------------------- fetch FSM
  logic       ready;   // cell data available for a load on this tick
  logic [7:0] p1_now;  // plane-1 byte, bypassing the holding reg on its ack

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    hold_p0_d  = hold_p0_q;
    hold_p1_d  = hold_p1_q;
    valid_d    = valid_q;
    underrun_d = underrun_q;
    ready      = valid_q;
    p1_now     = hold_p1_q;
    case (state_q)
      FS_REQ_P0: if (i_vram_ack) begin
        hold_p0_d = i_vram_data;
        state_d   = FS_REQ_P1;
      end
      FS_REQ_P1: if (i_vram_ack) begin
        hold_p1_d = i_vram_data;
        p1_now    = i_vram_data;
        ready     = 1'b1;
        state_d   = FS_DONE;
      end
      FS_DONE: begin
        ready   = 1'b1;
        valid_d = 1'b1;
        state_d = FS_IDLE;
      end
      default: ;
    endcase
    // A load consumes finished data; an unfinished fetch is stale and is
    // dropped. With no fetch outstanding at all (first cell after reset)
    // the cell is blanked but nothing was late, so no underrun.
    if (boundary) begin
      valid_d = 1'b0;
      if (!ready && state_q != FS_IDLE) underrun_d = 1'b1;
      state_d = FS_IDLE;
    end
    if (fetch_start) begin
      state_d = FS_REQ_P0;
      base_d  = {~page_d, start_cell, start_row};
    end
    req_d  = (state_d == FS_REQ_P0) || (state_d == FS_REQ_P1);
    addr_d = {(state_d == FS_REQ_P1) ? P1_SEG : P0_SEG, base_d};
  end

  // -------------------------------------------------------- pixel pipeline
  logic [7:0] src_p0, src_p1;
  mode_e      mode_cur;
  logic       blank_cur;
  logic [3:0] colour;

  always_comb begin
    src_p0    = sh_p0_q;
    src_p1    = sh_p1_q;
    mode_cur  = mode_q;
    blank_cur = blank_q;
    if (boundary) begin
      mode_cur  = mode_e'(i_video_mode[2:0]);
      blank_cur = !ready;
      src_p0    = ready ? hold_p0_q : 8'h00;
      src_p1    = ready ? p1_now : 8'h00;
    end
    case (mode_cur)
      MODE_MONO: colour = src_p0[7] ? i_colors_pseudo[7:4] : i_colors_pseudo[3:0];
      MODE_C4:   colour = {src_p1[7], 1'b0, src_p0[7], 1'b1};
      MODE_C16:  colour = src_p0[7] ? src_p1[7:4] : src_p1[3:0];
      default:   colour = 4'h0;
    endcase
    sh_p0_d = sh_p0_q;
    sh_p1_d = sh_p1_q;
    mode_d  = mode_q;
    blank_d = blank_q;
    rgbi_d  = rgbi_q;
    if (i_pix_ce) begin
      rgbi_d  = (vis && !blank_cur) ? colour : 4'h0;
      sh_p0_d = {src_p0[6:0], 1'b0};
      // Plane 1 is a per-pixel bitplane only in four-colour mode; in
      // sixteen-colour mode it is the cell's fg/bg pair and stays put.
      sh_p1_d = (mode_cur == MODE_C4) ? {src_p1[6:0], 1'b0} : src_p1;
      mode_d  = mode_cur;
      blank_d = blank_cur;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= FS_IDLE;
      page_q     <= 2'd0;
      base_q     <= '0;
      hold_p0_q  <= '0;
      hold_p1_q  <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      sh_p0_q    <= '0;
      sh_p1_q    <= '0;
      mode_q     <= MODE_MONO;
      blank_q    <= 1'b1;
      rgbi_q     <= 4'h0;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      base_q     <= base_d;
      hold_p0_q  <= hold_p0_d;
      hold_p1_q  <= hold_p1_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      sh_p0_q    <= sh_p0_d;
      sh_p1_q    <= sh_p1_d;
      mode_q     <= mode_d;
      blank_q    <= blank_d;
      rgbi_q     <= rgbi_d;
    end
  end

  assign o_vram_req  = req_q;
  assign o_vram_addr = addr_q;
  assign o_underrun  = underrun_q;
  assign o_rgbi      = rgbi_q;

endmodule

// File: tb/tb_orion_pro_video.sv
// Directed bench for orion_pro_video. Vertical timing is shortened (16
// visible of 24 lines, vsync on 18-21) so full frames fit a short run;
// horizontal timing is the real 640-slot line. The pixel tick runs every
// clock, so pos counts the pixel whose outputs are visible after each edge.
module tb_orion_pro_video;

  localparam int VA = 16, VT = 24, VSS = 18, VSL = 4;
  localparam int HT = 640;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n, pix_ce, int_en;
  logic [4:0]  video_mode;
  logic [7:0]  screen_mode, colors;
  logic        vram_req, vram_ack;
  logic [20:0] vram_addr;
  logic [7:0]  vram_data;
  logic [3:0]  rgbi;
  logic        hsync_n, vsync_n, de, int_n, frame_end, underrun;

  logic [7:0] p0_val, p1_val;
  logic       stall_en;
  logic [5:0] stall_cell;

  always #5 clk = ~clk;

  // RAM model: answers in the request cycle; plane 1 lives at bit 16.
  assign vram_ack  = vram_req && !(stall_en && vram_addr[13:8] == stall_cell);
  assign vram_data = vram_addr[16] ? p1_val : p0_val;

  orion_pro_video #(
    .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL)
  ) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_pix_ce       (pix_ce),
    .i_video_mode   (video_mode),
    .i_screen_mode  (screen_mode),
    .i_colors_pseudo(colors),
    .i_int_en       (int_en),
    .o_vram_req     (vram_req),
    .o_vram_addr    (vram_addr),
    .i_vram_ack     (vram_ack),
    .i_vram_data    (vram_data),
    .o_rgbi         (rgbi),
    .o_hsync_n      (hsync_n),
    .o_vsync_n      (vsync_n),
    .o_de           (de),
    .o_int_n        (int_n),
    .o_frame_end    (frame_end),
    .o_underrun     (underrun)
  );

  int n_assert = 0, n_fail = 0;
  int pos = -1;
  int hs_low = 0, vs_low = 0, de_hi = 0, int_low = 0, fe_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    pos++;
    if (frame_end) fe_cnt++;
    if (pos < FRAME) begin
      if (!hsync_n) hs_low++;
      if (!vsync_n) vs_low++;
      if (de) de_hi++;
      if (!int_n) int_low++;
    end
  endtask

  task automatic run_to(input int target);
    while (pos < target) step();
  endtask

  logic [3:0] mono_exp [8] = '{4'hF, 4'h1, 4'hF, 4'h1, 4'h1, 4'hF, 4'h1, 4'hF};

  initial begin
    rst_n = 1'b0; pix_ce = 1'b1; int_en = 1'b1;
    video_mode = 5'd0; screen_mode = 8'h00; colors = 8'hF1;
    p0_val = 8'hA5; p1_val = 8'h2C; stall_en = 1'b0; stall_cell = 6'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_hsync_n", hsync_n, 1);
    chk("rst_vsync_n", vsync_n, 1);
    chk("rst_de", de, 0);
    chk("rst_rgbi", rgbi, 0);
    chk("rst_int_n", int_n, 1);
    chk("rst_frame_end", frame_end, 0);
    chk("rst_req", vram_req, 0);
    chk("rst_underrun", underrun, 0);
    rst_n = 1'b1;

    // Line 0: first cell has nothing fetched; cell 1 fetch starts at once.
    run_to(0);
    chk("l0_de", de, 1);
    chk("l0_rgbi_blank", rgbi, 0);
    chk("l0_req", vram_req, 1);
    chk("l0_addr_c1", vram_addr, 21'h00C100);
    run_to(383); chk("de_last_vis", de, 1);
    run_to(384); chk("de_first_blank", de, 0);
    run_to(415); chk("hs_before", hsync_n, 1);
    run_to(416); chk("hs_start", hsync_n, 0);
    run_to(479); chk("hs_last", hsync_n, 0);
    run_to(480); chk("hs_end", hsync_n, 1);

    // Mono, line 1 cell 0: A5 with F1 palette.
    for (int i = 0; i < 8; i++) begin
      run_to(HT + i);
      chk($sformatf("mono_px%0d", i), rgbi, mono_exp[i]);
    end
    chk("no_underrun_l1", underrun, 0);
    run_to(700);
    p0_val = 8'hF0;

    // Cell 5 row 10 fetch addresses, page 0.
    run_to(10*HT + 32);
    chk("p0_req", vram_req, 1);
    chk("p0_addr", vram_addr, 21'h00C50A);
    run_to(10*HT + 33);
    chk("p1_req", vram_req, 1);
    chk("p1_addr", vram_addr, 21'h01C50A);

    // Mid-line switch to sixteen-colour: takes effect at the next cell.
    run_to(11*HT + 100);
    video_mode = 5'd3;
    run_to(11*HT + 103); chk("mono_before_switch", rgbi, 4'h1);
    for (int i = 0; i < 8; i++) begin
      run_to(11*HT + 104 + i);
      chk($sformatf("c16_px%0d", i), rgbi, (i < 4) ? 4'h2 : 4'hC);
    end

    // Four-colour: p0=F0, p1=2C.
    run_to(12*HT + 100);
    video_mode = 5'd2;
    run_to(12*HT + 104); chk("c4_px0", rgbi, 4'h3);
    run_to(12*HT + 105); chk("c4_px1", rgbi, 4'h3);
    run_to(12*HT + 106); chk("c4_px2", rgbi, 4'hB);
    run_to(12*HT + 108); chk("c4_px4", rgbi, 4'h9);
    run_to(12*HT + 120);
    video_mode = 5'd3;

    // Late fetch on line 14 cell 5.
    run_to(14*HT + 10);
    stall_cell = 6'd5; stall_en = 1'b1;
    run_to(14*HT + 32); chk("stall_addr", vram_addr, 21'h00C50E);
    run_to(14*HT + 39);
    chk("stall_req_held", vram_req, 1);
    chk("stall_no_underrun_yet", underrun, 0);
    run_to(14*HT + 40);
    chk("underrun_set", underrun, 1);
    chk("underrun_cell_blank0", rgbi, 0);
    chk("next_fetch_addr", vram_addr, 21'h00C60E);
    run_to(14*HT + 41);
    stall_en = 1'b0;
    run_to(14*HT + 47); chk("underrun_cell_blank7", rgbi, 0);
    run_to(14*HT + 48); chk("after_underrun_px0", rgbi, 4'h2);
    run_to(14*HT + 52); chk("after_underrun_px4", rgbi, 4'hC);

    run_to(16*HT); chk("de_line16", de, 0);

    // Frame end / vsync / interrupt.
    run_to(17*HT + 639);
    chk("fe_pulse", frame_end, 1);
    chk("int_low_start", int_n, 0);
    chk("vs_before", vsync_n, 1);
    run_to(18*HT);
    chk("fe_one_clock", frame_end, 0);
    chk("vs_start", vsync_n, 0);
    run_to(17*HT + 639 + 127); chk("int_low_last", int_n, 0);
    run_to(17*HT + 639 + 128); chk("int_released", int_n, 1);

    run_to(FRAME);
    chk("frame_hs_low", hs_low, 64 * VT);
    chk("frame_vs_low", vs_low, VSL * HT);
    chk("frame_de_hi", de_hi, 384 * VA);
    chk("frame_int_low", int_low, 128);
    chk("frame_fe_cnt", fe_cnt, 1);
    chk("frame1_cell0", rgbi, 4'h2);

    // Second frame: disabling the interrupt releases int_n at once.
    run_to(FRAME + 17*HT + 640);
    chk("int2_low", int_n, 0);
    int_en = 1'b0;
    run_to(FRAME + 17*HT + 641);
    chk("int_en_release", int_n, 1);
    chk("fe_two_frames", fe_cnt, 2);

    // Reset in the middle of a held request.
    stall_cell = 6'd0; stall_en = 1'b1;
    run_to(2*FRAME - 8);
    chk("pre_rst_req", vram_req, 1);
    chk("pre_rst_addr", vram_addr, 21'h00C000);
    run_to(2*FRAME - 7);
    chk("underrun_sticky", underrun, 1);
    rst_n = 1'b0; stall_en = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_req", vram_req, 0);
    chk("rst_mid_underrun", underrun, 0);
    chk("rst_mid_de", de, 0);
    @(posedge clk); #1;
    chk("rst_ack_ignored", vram_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
